tm_program_driver: RTL and testbench

//  Initiator side of the Turing-machine button handshake (input_data/Next/Done/Compute_done).

---
 rtl/tm_program_driver_if.sv | 25 ++
 rtl/tm_program_driver.sv | 146 ++++++++++++++
 tb/tb_tm_program_driver.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm_program_driver_if.sv
// Host/machine-side signal bundle for the Turing-machine program driver.
// The host (loader plus machine model) drives through master; the driver uses slave.
interface tm_program_driver_if #(parameter int DW = 4);
  logic          load_valid;
  logic          load_ready;
  logic [DW-1:0] load_data;
  logic          start;
  logic          compute_done;
  logic [DW-1:0] input_data;
  logic          Next;
  logic          Done;
  logic          busy;
  logic          finished;
  logic          timeout;
  logic [15:0]   step_count;

  modport master (
    output load_valid, load_data, start, compute_done,
    input  load_ready, input_data, Next, Done, busy, finished, timeout, step_count
  );
  modport slave (
    input  load_valid, load_data, start, compute_done,
    output load_ready, input_data, Next, Done, busy, finished, timeout, step_count
  );
endinterface

// File: rtl/tm_program_driver.sv
// Buffers a program/tape word stream and replays it into the Turing machine as Next pulses,
// then Done, then Next step pulses until compute_done or the step limit.
module tm_program_driver #(
  parameter int DW        = 4,
  parameter int DEPTH     = 16,
  parameter int HOLD      = 2,
  parameter int MAX_STEPS = 255
) (
  input  logic clock,
  input  logic reset,
  tm_program_driver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [15:0]   STEP_MAX  = 16'(MAX_STEPS);

  typedef enum logic [2:0] {IDLE, LD_HI, LD_LO, DN_HI, DN_LO, RUN_HI, RUN_LO, FINISH} state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0] count;
  logic [HW-1:0] hold_cnt;
  logic          hold_end, push;

  assign bus.load_ready = (state == IDLE) && (count != CW'(DEPTH));
  assign push           = bus.load_valid && bus.load_ready;
  assign hold_end       = (hold_cnt == HOLD_LAST);
  assign rd_next        = rd_ptr + AW'(1);

  // Storage has no reset: the pointers alone define what is valid.
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= bus.load_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.input_data <= '0;
      bus.Next       <= 1'b0;
      bus.Done       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.finished   <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.step_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (count != '0) begin
              state          <= LD_HI;
              bus.Next       <= 1'b1;
              bus.input_data <= mem[rd_ptr];
            end else begin
              state    <= DN_HI;
              bus.Done <= 1'b1;
            end
          end
        end
        LD_HI: begin
          if (hold_end) begin
            state    <= LD_LO;
            bus.Next <= 1'b0;
            hold_cnt <= '0;
          end else hold_cnt <= hold_cnt + HW'(1);
        end
        LD_LO: begin
          if (hold_end) begin
            hold_cnt <= '0;
            rd_ptr   <= rd_next;
            count    <= count - CW'(1);
            if (count > CW'(1)) begin
              state          <= LD_HI;
              bus.Next       <= 1'b1;
              bus.input_data <= mem[rd_next];
            end else begin
              state          <= DN_HI;
              bus.Done       <= 1'b1;
              bus.input_data <= '0;
            end
          end else hold_cnt <= hold_cnt + HW'(1);
        end
        DN_HI, DN_LO, RUN_HI, RUN_LO: begin
          // The machine may report completion at any point after Done starts.
          if (bus.compute_done) begin
            state        <= FINISH;
            hold_cnt     <= '0;
            bus.Next     <= 1'b0;
            bus.Done     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.finished <= 1'b1;
          end else if (!hold_end) begin
            hold_cnt <= hold_cnt + HW'(1);
          end else begin
            hold_cnt <= '0;
            case (state)
              DN_HI: begin
                state    <= DN_LO;
                bus.Done <= 1'b0;
              end
              DN_LO, RUN_LO: begin
                if (state == RUN_LO && bus.step_count == STEP_MAX) begin
                  state        <= FINISH;
                  bus.busy     <= 1'b0;
                  bus.finished <= 1'b1;
                  bus.timeout  <= 1'b1;
                end else begin
                  state          <= RUN_HI;
                  bus.Next       <= 1'b1;
                  bus.step_count <= (bus.step_count == STEP_MAX) ? STEP_MAX
                                                                 : bus.step_count + 16'd1;
                end
              end
              RUN_HI: begin
                state    <= RUN_LO;
                bus.Next <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        FINISH: begin
          hold_cnt <= '0;
          if (bus.start) begin
            state          <= IDLE;
            bus.finished   <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.step_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tm_program_driver.sv
// Randomized bench for tm_program_driver: a cycle-indexed waveform model of the
// load/Done/run phases predicts Next/Done/input_data/busy and the finish status.
module tb_tm_program_driver;
  localparam int DW = 4, DEPTH = 16, H = 2, MAXS = 255;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  tm_program_driver_if #(.DW(DW)) bus();
  tm_program_driver #(.DW(DW), .DEPTH(DEPTH), .HOLD(H), .MAX_STEPS(MAXS)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  typedef struct {
    bit            nx;
    bit            dn;
    logic [DW-1:0] d;
    int            steps;
  } exp_t;

  logic [DW-1:0] prog[$];
  int vectors = 0;
  int errors  = 0;

  // Expected outputs in cycle t after the start edge: each word is H cycles Next high
  // then H low, then H cycles of Done, H quiet, then steps of H high / H low.
  function automatic exp_t model_at(int t);
    exp_t e;
    int lp, r;
    e.nx = 0; e.dn = 0; e.d = '0; e.steps = 0;
    lp = prog.size() * 2 * H;
    if (t < lp) begin
      e.d  = prog[t / (2 * H)];
      e.nx = (t % (2 * H)) < H;
    end else if (t < lp + 2 * H) begin
      e.dn = (t - lp) < H;
    end else begin
      r       = t - lp - 2 * H;
      e.steps = r / (2 * H) + 1;
      e.nx    = (r % (2 * H)) < H;
    end
    return e;
  endfunction

  task automatic idle_inputs();
    bus.load_valid = 0; bus.load_data = '0; bus.start = 0; bus.compute_done = 0;
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    prog.delete();
  endtask

  task automatic load_prog();
    foreach (prog[i]) begin
      bus.load_valid = 1; bus.load_data = prog[i];
      next_cycle();
    end
    bus.load_valid = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1;
    next_cycle();
    bus.start = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clock);
    vectors++;
    if ({bus.load_ready, bus.Next, bus.Done, bus.busy, bus.finished, bus.timeout} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags got %b want 100000",
               {bus.load_ready, bus.Next, bus.Done, bus.busy, bus.finished, bus.timeout});
    end
    vectors++;
    if (bus.step_count !== 16'd0) begin
      errors++; $display("FAIL reset_step_count got %0d want 0", bus.step_count);
    end
    vectors++;
    if (bus.input_data !== '0) begin
      errors++; $display("FAIL reset_input_data got %0d want 0", bus.input_data);
    end
    next_cycle();
  endtask

  // Program 3,5,1; completion reported in the low phase of the 4th step.
  task automatic test_directed_program();
    exp_t e;
    int tc;
    apply_reset();
    prog = '{4'd3, 4'd5, 4'd1};
    load_prog();
    pulse_start();
    tc = 3 * 2 * H + 2 * H + 3 * 2 * H + H;
    for (int t = 0; t <= tc + 1; t++) begin
      bus.compute_done = (t >= tc);
      @(negedge clock);
      vectors++;
      if (t <= tc) begin
        e = model_at(t);
        if ({bus.Next, bus.Done, bus.busy, bus.input_data} !== {e.nx, e.dn, 1'b1, e.d}) begin
          errors++;
          $display("FAIL directed_trace t=%0d got N%b D%b B%b d%0d want N%b D%b B1 d%0d",
                   t, bus.Next, bus.Done, bus.busy, bus.input_data, e.nx, e.dn, e.d);
        end
      end else if ({bus.finished, bus.timeout, bus.Next, bus.busy} !== 4'b1000 ||
                   bus.step_count !== 16'd4) begin
        errors++;
        $display("FAIL directed_finish got fin%b to%b N%b B%b steps=%0d want fin1 to0 N0 B0 steps=4",
                 bus.finished, bus.timeout, bus.Next, bus.busy, bus.step_count);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_full_buffer();
    exp_t e;
    logic [DW-1:0] w;
    apply_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      w = DW'($urandom);
      bus.load_valid = 1; bus.load_data = w;
      @(negedge clock);
      vectors++;
      if (bus.load_ready !== (i < DEPTH)) begin
        errors++;
        $display("FAIL full_load_ready offer=%0d got %b want %b", i, bus.load_ready, i < DEPTH);
      end
      if (i < DEPTH) prog.push_back(w);
      next_cycle();
    end
    bus.load_valid = 0;
    pulse_start();
    // Replay must show exactly DEPTH words followed by Done.
    for (int t = 0; t < DEPTH * 2 * H + 2 * H; t++) begin
      @(negedge clock);
      e = model_at(t);
      vectors++;
      if ({bus.Next, bus.Done, bus.input_data} !== {e.nx, e.dn, e.d}) begin
        errors++;
        $display("FAIL full_replay t=%0d got N%b D%b d%0d want N%b D%b d%0d",
                 t, bus.Next, bus.Done, bus.input_data, e.nx, e.dn, e.d);
      end
      next_cycle();
    end
  endtask

  task automatic test_empty_start();
    exp_t e;
    apply_reset();
    pulse_start();
    for (int t = 0; t < 3 * H; t++) begin
      @(negedge clock);
      e = model_at(t);
      vectors++;
      if ({bus.Next, bus.Done, bus.busy} !== {e.nx, e.dn, 1'b1}) begin
        errors++;
        $display("FAIL empty_start t=%0d got N%b D%b B%b want N%b D%b B1",
                 t, bus.Next, bus.Done, bus.busy, e.nx, e.dn);
      end
      next_cycle();
    end
  endtask

  // Random programs, random completion point, junk start/load traffic while busy,
  // and a restart from FINISH between runs (no reset).
  task automatic test_random_programs();
    exp_t e, ef;
    int n, lp, tc;
    apply_reset();
    for (int it = 0; it < 8; it++) begin
      n = (it == 0) ? 0 : int'($urandom_range(1, DEPTH));
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(DW'($urandom));
      load_prog();
      pulse_start();
      lp = n * 2 * H;
      tc = int'($urandom_range(lp, lp + 2 * H + 8 * 2 * H));
      ef = model_at(tc);
      for (int t = 0; t <= tc + 1; t++) begin
        bus.compute_done = (t >= tc);
        bus.start        = (t < tc) && ($urandom_range(0, 3) == 0);
        bus.load_valid   = (t <= tc) && ($urandom_range(0, 1) == 1);
        bus.load_data    = DW'($urandom);
        @(negedge clock);
        vectors++;
        if (t <= tc) begin
          e = model_at(t);
          if ({bus.Next, bus.Done, bus.busy, bus.load_ready, bus.input_data} !==
              {e.nx, e.dn, 1'b1, 1'b0, e.d}) begin
            errors++;
            $display("FAIL random_trace it=%0d t=%0d got N%b D%b B%b R%b d%0d want N%b D%b B1 R0 d%0d",
                     it, t, bus.Next, bus.Done, bus.busy, bus.load_ready, bus.input_data,
                     e.nx, e.dn, e.d);
          end
        end else if ({bus.finished, bus.timeout, bus.Next, bus.Done} !== 4'b1000 ||
                     bus.step_count !== 16'(ef.steps)) begin
          errors++;
          $display("FAIL random_finish it=%0d got fin%b to%b N%b D%b steps=%0d want fin1 to0 N0 D0 steps=%0d",
                   it, bus.finished, bus.timeout, bus.Next, bus.Done, bus.step_count, ef.steps);
        end
        next_cycle();
      end
      idle_inputs();
      pulse_start();
      @(negedge clock);
      vectors++;
      if ({bus.finished, bus.timeout, bus.busy, bus.load_ready} !== 4'b0001 ||
          bus.step_count !== 16'd0) begin
        errors++;
        $display("FAIL random_restart it=%0d got fin%b to%b B%b R%b steps=%0d want fin0 to0 B0 R1 steps=0",
                 it, bus.finished, bus.timeout, bus.busy, bus.load_ready, bus.step_count);
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int tend;
    apply_reset();
    prog = '{DW'($urandom), DW'($urandom)};
    load_prog();
    pulse_start();
    tend = prog.size() * 2 * H + 2 * H + MAXS * 2 * H;
    for (int t = 0; t <= tend; t++) begin
      @(negedge clock);
      vectors++;
      if (t < tend) begin
        e = model_at(t);
        if ({bus.Next, bus.Done, bus.input_data} !== {e.nx, e.dn, e.d} ||
            (e.steps > 0 && bus.step_count !== 16'(e.steps))) begin
          errors++;
          $display("FAIL timeout_trace t=%0d got N%b D%b d%0d steps=%0d want N%b D%b d%0d steps=%0d",
                   t, bus.Next, bus.Done, bus.input_data, bus.step_count, e.nx, e.dn, e.d, e.steps);
        end
      end else if ({bus.finished, bus.timeout, bus.Next, bus.busy} !== 4'b1100 ||
                   bus.step_count !== 16'(MAXS)) begin
        errors++;
        $display("FAIL timeout_finish got fin%b to%b N%b B%b steps=%0d want fin1 to1 N0 B0 steps=%0d",
                 bus.finished, bus.timeout, bus.Next, bus.busy, bus.step_count, MAXS);
      end
      next_cycle();
    end
    pulse_start();
    @(negedge clock);
    vectors++;
    if ({bus.finished, bus.timeout} !== 2'b00 || bus.step_count !== 16'd0) begin
      errors++;
      $display("FAIL timeout_clear got fin%b to%b steps=%0d want fin0 to0 steps=0",
               bus.finished, bus.timeout, bus.step_count);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    prog = '{4'd9, 4'd6, 4'd12};
    load_prog();
    pulse_start();
    repeat (2 * H) next_cycle();
    @(negedge clock);
    vectors++;
    if ({bus.Next, bus.input_data} !== {1'b1, prog[1]}) begin
      errors++;
      $display("FAIL midreset_pre got N%b d%0d want N1 d%0d", bus.Next, bus.input_data, prog[1]);
    end
    #1 reset = 1;
    #1;
    vectors++;
    if ({bus.Next, bus.Done, bus.busy, bus.load_ready, bus.input_data} !== {4'b0001, 4'd0}) begin
      errors++;
      $display("FAIL midreset_async got N%b D%b B%b R%b d%0d want N0 D0 B0 R1 d0",
               bus.Next, bus.Done, bus.busy, bus.load_ready, bus.input_data);
    end
    @(posedge clock); #1 reset = 0;
    prog.delete();
    pulse_start();
    @(negedge clock);
    vectors++;
    if ({bus.Next, bus.Done} !== 2'b01) begin
      errors++;
      $display("FAIL midreset_flushed got N%b D%b want N0 D1", bus.Next, bus.Done);
    end
    next_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_directed_program();
    test_full_buffer();
    test_empty_start();
    test_random_programs();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
